// File: rtl/histeq_pkg.sv
// histeq_pkg: shared widths, limits and FSM state encoding for the histogram-equalisation output stage.
package histeq_pkg;
    localparam int PIX_W        = 8;
    localparam int WORD_W       = 128;
    localparam int ADDR_W       = 16;
    localparam int PIX_PER_WORD = 16;
    localparam int MAX_LEVEL    = 255;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        LOOKUP = 3'd2,
        WRITE  = 3'd3,
        DONE   = 3'd4
    } state_e;
endpackage

// File: rtl/histeq_map.sv
// histeq_map: maps one CDF entry to an equalised level, rounded to nearest and clamped to MAX_LEVEL.
module histeq_map
    import histeq_pkg::*;
#(
    parameter int CDF_W = 16
) (
    input  logic [CDF_W-1:0] cdf_i,
    input  logic [PIX_W-1:0] cdf_min_i,
    input  logic [23:0]      num_pixels_i,
    output logic [PIX_W-1:0] level_o
);
    logic        valid;
    logic [31:0] den;
    logic [31:0] num;
    logic [31:0] quo;

    // A non-positive denominator or a CDF below the minimum both map to black.
    assign valid   = (num_pixels_i > 24'(cdf_min_i)) && (cdf_i >= CDF_W'(cdf_min_i));
    assign den     = 32'(num_pixels_i) - 32'(cdf_min_i);
    assign num     = 32'(cdf_i - CDF_W'(cdf_min_i)) * 32'(MAX_LEVEL) + (den >> 1);
    assign quo     = num / (valid ? den : 32'd1);
    assign level_o = !valid ? '0 : (quo > 32'(MAX_LEVEL)) ? PIX_W'(MAX_LEVEL) : quo[PIX_W-1:0];
endmodule

// File: rtl/histeq_output_pipeline.sv
// histeq_output_pipeline: streams image words from M3, looks up each pixel's CDF in M2 and writes equalised words to M4.
module histeq_output_pipeline
    import histeq_pkg::*;
#(
    parameter int NUM_PIXELS = 64,
    parameter int NUM_WORDS  = NUM_PIXELS / 16,
    parameter int CDF_W      = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [PIX_W-1:0]    CdfMin,
    input  logic [WORD_W-1:0]   M2SP_ReadBus,
    output logic [ADDR_W-1:0]   M2SP_ReadAddress,
    input  logic [WORD_W-1:0]   M3SP_ReadBus,
    output logic [ADDR_W-1:0]   M3SP_ReadAddress,
    output logic                WriteEnable,
    output logic [WORD_W-1:0]   Output_MEMBus,
    output logic [ADDR_W-1:0]   Output_MEMAddress,
    output logic                done
);
    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   w_q, w_d;
    logic [4:0]          i_q, i_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic [WORD_W-1:0]   out_q, out_d;
    logic [PIX_W-1:0]    cdf_min_q, cdf_min_d;
    logic                start_q;
    logic                start_edge;
    logic [WORD_W-1:0]   pix_src;
    logic [PIX_W-1:0]    pix;
    logic [3:0]          wr_lane;
    logic [PIX_W-1:0]    mapped;
    logic                unused_bits;

    assign start_edge = start & ~start_q;
    // The first lookup reads straight off the M3 bus so the fetch costs only one cycle.
    assign pix_src    = (i_q == 5'd0) ? M3SP_ReadBus : word_q;
    assign pix        = pix_src[8*i_q[3:0] +: PIX_W];
    assign wr_lane    = 4'(i_q - 5'd1);
    assign unused_bits = ^M2SP_ReadBus[WORD_W-1:CDF_W];

    assign M2SP_ReadAddress  = (state_q == LOOKUP && !i_q[4]) ? {8'h00, pix} : '0;
    assign M3SP_ReadAddress  = (state_q == FETCH || state_q == LOOKUP) ? w_q : '0;
    assign WriteEnable       = (state_q == WRITE);
    assign Output_MEMAddress = (state_q == WRITE) ? w_q : '0;
    assign Output_MEMBus     = (state_q == WRITE) ? out_q : '0;
    assign done              = (state_q == DONE);

    histeq_map #(.CDF_W(CDF_W)) u_map (
        .cdf_i        (M2SP_ReadBus[CDF_W-1:0]),
        .cdf_min_i    (cdf_min_q),
        .num_pixels_i (24'(NUM_PIXELS)),
        .level_o      (mapped)
    );

    always_comb begin
        state_d   = state_q;
        w_d       = w_q;
        i_d       = i_q;
        word_d    = word_q;
        out_d     = out_q;
        cdf_min_d = cdf_min_q;
        case (state_q)
            IDLE, DONE: begin
                if (start_edge) begin
                    state_d   = FETCH;
                    w_d       = '0;
                    cdf_min_d = CdfMin;
                end
            end
            FETCH: begin
                state_d = LOOKUP;
                i_d     = '0;
            end
            LOOKUP: begin
                if (i_q == 5'd0) word_d = M3SP_ReadBus;
                if (i_q != 5'd0) out_d[8*wr_lane +: PIX_W] = mapped;
                i_d = i_q + 5'd1;
                if (i_q == 5'(PIX_PER_WORD)) state_d = WRITE;
            end
            WRITE: begin
                if (w_q == ADDR_W'(NUM_WORDS - 1)) begin
                    state_d = DONE;
                end else begin
                    w_d     = w_q + 1'b1;
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            w_q       <= '0;
            i_q       <= '0;
            word_q    <= '0;
            out_q     <= '0;
            cdf_min_q <= '0;
            start_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            w_q       <= w_d;
            i_q       <= i_d;
            word_q    <= word_d;
            out_q     <= out_d;
            cdf_min_q <= cdf_min_d;
            start_q   <= start;
        end
    end
endmodule

// File: tb/tb_histeq_output_pipeline.sv
// tb_histeq_output_pipeline: directed/randomised frames against an arithmetic model of the equalisation mapping.
module tb_histeq_output_pipeline;
    localparam int NP = 64;
    localparam int NW = NP / 16;

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic [7:0]   CdfMin;
    logic [127:0] M2SP_ReadBus;
    logic [127:0] M3SP_ReadBus;
    logic [15:0]  M2SP_ReadAddress;
    logic [15:0]  M3SP_ReadAddress;
    logic         WriteEnable;
    logic [127:0] Output_MEMBus;
    logic [15:0]  Output_MEMAddress;
    logic         done;

    logic [15:0]  cdf_mem [256];
    logic [127:0] img [NW];
    logic [127:0] log_data [$];
    logic [15:0]  log_addr [$];
    int n_vec = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    histeq_output_pipeline #(.NUM_PIXELS(NP), .NUM_WORDS(NW), .CDF_W(16)) dut (
        .clock             (clock),
        .reset             (reset),
        .start             (start),
        .CdfMin            (CdfMin),
        .M2SP_ReadBus      (M2SP_ReadBus),
        .M2SP_ReadAddress  (M2SP_ReadAddress),
        .M3SP_ReadBus      (M3SP_ReadBus),
        .M3SP_ReadAddress  (M3SP_ReadAddress),
        .WriteEnable       (WriteEnable),
        .Output_MEMBus     (Output_MEMBus),
        .Output_MEMAddress (Output_MEMAddress),
        .done              (done)
    );

    // Registered-read SRAM models for M2/M3 and a write log standing in for M4.
    always @(posedge clock) begin
        M2SP_ReadBus <= {112'b0, cdf_mem[M2SP_ReadAddress[7:0]]};
        M3SP_ReadBus <= img[int'(M3SP_ReadAddress) % NW];
        if (WriteEnable) begin
            log_data.push_back(Output_MEMBus);
            log_addr.push_back(Output_MEMAddress);
        end
    end

    function automatic int ref_level(int cdf, int cmin);
        int den;
        int v;
        den = NP - cmin;
        if (den <= 0 || cdf < cmin) return 0;
        v = ((cdf - cmin) * 255 + den / 2) / den;
        return (v > 255) ? 255 : v;
    endfunction

    function automatic logic [127:0] golden(int k, int cmin);
        logic [127:0] g;
        logic [127:0] wd;
        wd = img[k];
        for (int b = 0; b < 16; b++) g[8*b +: 8] = 8'(ref_level(int'(cdf_mem[wd[8*b +: 8]]), cmin));
        return g;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic fill(input int maxc);
        for (int v = 0; v < 256; v++) cdf_mem[v] = 16'($urandom_range(0, maxc));
        for (int k = 0; k < NW; k++) img[k] = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // Produces a fresh start rising edge and waits (bounded) for done; leaves start high.
    task automatic run_frame(input int cmin, output int base);
        int cyc;
        start = 1'b0;
        tick(1);
        base = log_data.size();
        CdfMin = 8'(cmin);
        start = 1'b1;
        tick(1);
        check("busy_done_low", done, 1'b0);
        for (cyc = 0; cyc < 200 && !done; cyc++) tick(1);
        check("done_rise", done, 1'b1);
        check("writes_at_done", 128'(log_data.size() - base), 128'(NW));
    endtask

    task automatic check_frame(input int base, input int cmin);
        for (int k = 0; k < NW; k++) begin
            if (base + k < log_data.size()) begin
                check("m4_addr", log_addr[base + k], 128'(k));
                check("m4_word", log_data[base + k], golden(k, cmin));
            end
        end
    endtask

    initial begin
        int b;
        int b2;
        int cm;
        logic [127:0] w0;
        reset = 1'b1;
        start = 1'b0;
        CdfMin = 8'd0;
        fill(70);
        tick(1);
        reset = 1'b0;
        check("rst_we", WriteEnable, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_m2addr", M2SP_ReadAddress, 16'd0);
        check("rst_m3addr", M3SP_ReadAddress, 16'd0);
        check("rst_m4addr", Output_MEMAddress, 16'd0);
        check("rst_bus", Output_MEMBus, 128'd0);
        b = log_data.size();
        tick(20);
        check("idle_no_write", 128'(log_data.size() - b), 128'd0);

        // Example image values with CdfMin=1, plus random filler pixels and CDFs.
        fill(70);
        w0 = img[0];
        w0[31:0] = {8'd154, 8'd79, 8'd55, 8'd52};
        img[0] = w0;
        cdf_mem[52] = 16'd1;
        cdf_mem[55] = 16'd4;
        cdf_mem[79] = 16'd46;
        cdf_mem[154] = 16'd64;
        run_frame(1, b);
        w0 = log_data[b];
        check("pix52", w0[7:0], 8'd0);
        check("pix55", w0[15:8], 8'd12);
        check("pix79", w0[23:16], 8'd182);
        check("pix154", w0[31:24], 8'd255);
        check_frame(b, 1);

        // Held start must not re-trigger; a fresh edge reproduces identical words.
        b2 = log_data.size();
        tick(30);
        check("level_no_write", 128'(log_data.size() - b2), 128'd0);
        check("level_done_held", done, 1'b1);
        run_frame(1, b2);
        for (int k = 0; k < NW; k++) check("rerun_same", log_data[b2 + k], log_data[b + k]);

        // Byte order: pixels 0x00..0x0F in word 0, CDF[v]=v+1.
        for (int v = 0; v < 16; v++) cdf_mem[v] = 16'(v + 1);
        img[0] = 128'h0F0E0D0C0B0A09080706050403020100;
        run_frame(1, b);
        w0 = log_data[b];
        check("byte0", w0[7:0], 8'd0);
        check("byte1", w0[15:8], 8'd4);
        check("byte15", w0[127:120], 8'd61);
        check_frame(b, 1);

        // Reset during LOOKUP of word 2 aborts the frame.
        start = 1'b0;
        tick(1);
        fill(70);
        b = log_data.size();
        CdfMin = 8'd1;
        start = 1'b1;
        for (int c = 0; c < 200 && log_data.size() < b + 2; c++) tick(1);
        check("abort_two_writes", 128'(log_data.size() - b), 128'd2);
        tick(3);
        reset = 1'b1;
        start = 1'b0;
        tick(1);
        reset = 1'b0;
        check("abort_done", done, 1'b0);
        check("abort_we", WriteEnable, 1'b0);
        b2 = log_data.size();
        tick(40);
        check("abort_no_write", 128'(log_data.size() - b2), 128'd0);
        check("abort_done_still", done, 1'b0);
        run_frame(1, b);
        check_frame(b, 1);

        // den == 0 and den < 0 force every level to zero.
        run_frame(64, b);
        for (int k = 0; k < NW; k++) check("den_zero", log_data[b + k], 128'd0);
        run_frame(200, b);
        for (int k = 0; k < NW; k++) check("den_neg", log_data[b + k], 128'd0);

        // CDF just below CdfMin maps to zero.
        cm = $urandom_range(2, 40);
        fill(80);
        w0 = img[0];
        cdf_mem[w0[7:0]] = 16'(cm - 1);
        run_frame(cm, b);
        w0 = log_data[b];
        check("below_min", w0[7:0], 8'd0);
        check_frame(b, cm);

        for (int r = 0; r < 4; r++) begin
            cm = $urandom_range(0, 63);
            fill(90);
            run_frame(cm, b);
            check_frame(b, cm);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule

// File: doc/histeq_output_pipeline.md
Name: histeq_output_pipeline

Overview:
- Final stage of the histogram-equalisation engine.
- Streams packed 8-bit input pixels from image memory M3 and looks up each pixel's CDF value in CDF memory M2.
- Computes each equalised pixel, repacks 16 pixels per 128-bit word, and writes the words to output memory M4.
- All three memories are external 2-read/1-write SRAMs (sram_2R1W); this block owns one read port on M2, one read port on M3, and the M4 write port.

Parameters:
- NUM_PIXELS, 64, total pixels in the image; must be a multiple of 16.
- NUM_WORDS, NUM_PIXELS/16, count of 128-bit image words (4 by default).
- CDF_W, 16, width of a CDF entry.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begins a frame on its rising edge; held level is ignored.
- CdfMin  in  8  minimum non-zero CDF value; sampled on the start edge.
- M2SP_ReadBus  in  128  CDF read data; entry in bits [15:0].
- M2SP_ReadAddress  out  16  CDF address, equal to the pixel value 0..255.
- M3SP_ReadBus  in  128  input pixel word; pixel i in bits [8i+7:8i].
- M3SP_ReadAddress  out  16  input word address.
- WriteEnable  out  1  M4 write strobe, one cycle per word.
- Output_MEMBus  out  128  equalised pixel word, same byte order as input.
- Output_MEMAddress  out  16  M4 word address.
- done  out  1  frame complete.

Behaviour:
- Memory timing: SRAM read data is valid the cycle after the address is presented (registered read). An M4 write occurs on a clock edge while WriteEnable is high.
- Reset outputs: all addresses 0, Output_MEMBus 0, WriteEnable 0, done 0, FSM in IDLE.
- Reset mid-frame aborts the frame; no further writes occur.
- FSM states:
  - IDLE: wait for the start rising edge. Then latch CdfMin, set word index w=0, clear done.
  - FETCH: drive M3SP_ReadAddress=w; wait 1 cycle for data; latch the 128-bit word.
  - LOOKUP: for i=0..15, one per cycle, drive M2SP_ReadAddress={8'h00, pixel i}. The CDF for pixel i returns the next cycle; map it and store it in output byte i. This phase is pipelined: 16 address cycles plus 1 drain cycle.
  - WRITE: for one cycle, drive WriteEnable=1, Output_MEMAddress=w, Output_MEMBus=packed bytes. If w==NUM_WORDS-1, go to DONE; otherwise w++ and go to FETCH.
  - DONE: done=1, held until reset or the next start rising edge. A new start re-runs the frame from w=0.
- Per-word latency is 19 cycles; the default frame takes about 76 cycles.
- Mapping, with den = NUM_PIXELS - CdfMin:
  - out = floor(((cdf - CdfMin)*255 + floor(den/2)) / den), i.e. rounded to nearest.
  - Intermediate width is at least 24 bits.
  - If cdf < CdfMin, out=0.
  - If den==0 or den<0, out=0.
  - Result saturates at 255.
- start edges arriving while busy are ignored.
- WriteEnable is never high outside the WRITE state.

Decomposition:
- Shared package holds: the FSM state enum (IDLE, FETCH, LOOKUP, WRITE, DONE), PIX_W=8, WORD_W=128, ADDR_W=16, PIX_PER_WORD=16, MAX_LEVEL=255.
- Sub-module histeq_map: combinational (cdf, cdf_min, num_pixels) -> 8-bit equalised value, containing the division and rounding.
- The top level holds the FSM, pixel indexing and packing.

Test Plan:
- Reset then idle: reset=1 for 1 cycle -> WriteEnable=0, done=0, addresses 0; no M4 writes for 20 cycles without start.
- Example 8x8 image, CdfMin=1:
  - pixel 52 (cdf 1) -> 0
  - pixel 55 (cdf 4) -> 12
  - pixel 79 (cdf 46) -> 182
  - pixel 154 (cdf 64) -> 255
  - M4 words 0..3 match a golden model byte-for-byte; done rises after the 4th write.
- Byte order: M3 word 0 = 16'h..., bytes 0x00..0x0F with CDF[v]=v+1 and CdfMin=1 -> byte i = round(i*255/63), e.g. byte 1=4, byte 15=61.
- Level start: start held high after done -> no second frame. Deassert then reassert -> frame re-runs and M4 contents are identical.
- Reset mid-frame: reset asserted during LOOKUP of word 2 -> no further writes, done=0. A fresh start completes all 4 words correctly.
- Boundary: CdfMin=64 (den=0) -> all output bytes 0. A CDF entry below CdfMin -> 0.
